// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding,
// default counter width and the saturation-limit helper.
package pwm_pkg;

    // Default width of the measured low/high counts.
    localparam int PWM_WIDTH = 4;

    // Capture FSM: IDLE waits for a falling edge to align on a frame start,
    // LOW counts the low phase, HIGH counts the high phase.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOW  = 2'b01,
        HIGH = 2'b10
    } pwm_state_e;

    // Largest value a counter of the given width can hold.
    function automatic logic [31:0] sat_max(input int unsigned width);
        sat_max = (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes the asynchronous PWM input and derives registered level and
// edge strobes. The level output and both strobes come from the same flop
// stage, so a strobe is high in exactly the cycle the level first shows the
// new value.
module pwm_sync_edge
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   level_r;
    logic                   rise_r;
    logic                   fall_r;

    // Synchronizer chain, then one more stage that holds the previous level
    // and produces the edge strobes aligned to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], pulse_in};
            level_r <= sync_r[SYNC_STAGES-1];
            rise_r  <= sync_r[SYNC_STAGES-1] & ~level_r;
            fall_r  <= ~sync_r[SYNC_STAGES-1] & level_r;
        end
    end

    assign s    = level_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures the low and high phase lengths of a pulse stream in
// clk cycles and presents each completed low+high frame as a (d, w) pair
// behind a valid/ready handshake, with a sticky overrun flag for frames
// dropped while a result was still pending.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             enable,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] w_out,
    output logic             sat_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             s_s;
    logic             rise_s;
    logic             fall_s;

    pwm_state_e       state_r;
    pwm_state_e       state_next_s;
    logic [WIDTH-1:0] low_cnt_r;
    logic [WIDTH-1:0] low_cnt_next_s;
    logic [WIDTH-1:0] high_cnt_r;
    logic [WIDTH-1:0] high_cnt_next_s;
    logic             low_sat_r;
    logic             low_sat_next_s;
    logic             high_sat_r;
    logic             high_sat_next_s;
    logic             frame_end_s;

    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] w_r;
    logic             sat_r;
    logic             valid_r;
    logic             overrun_r;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .s        (s_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // FSM state and phase counters/saturation flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            low_cnt_r  <= CNT_ZERO;
            high_cnt_r <= CNT_ZERO;
            low_sat_r  <= 1'b0;
            high_sat_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            low_cnt_r  <= low_cnt_next_s;
            high_cnt_r <= high_cnt_next_s;
            low_sat_r  <= low_sat_next_s;
            high_sat_r <= high_sat_next_s;
        end
    end

    // Next-state logic: a fall starts a low phase (and closes a frame when
    // coming from HIGH), a rise starts the high phase. Counters stick at
    // their maximum and raise their own saturation flag instead of wrapping.
    always_comb begin
        state_next_s    = state_r;
        low_cnt_next_s  = low_cnt_r;
        high_cnt_next_s = high_cnt_r;
        low_sat_next_s  = low_sat_r;
        high_sat_next_s = high_sat_r;
        frame_end_s     = 1'b0;

        if (!enable) begin
            state_next_s    = IDLE;
            low_cnt_next_s  = CNT_ZERO;
            high_cnt_next_s = CNT_ZERO;
            low_sat_next_s  = 1'b0;
            high_sat_next_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        low_cnt_next_s  = CNT_ONE;
                        low_sat_next_s  = 1'b0;
                        high_sat_next_s = 1'b0;
                        state_next_s    = LOW;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                LOW: begin
                    if (rise_s) begin
                        high_cnt_next_s = CNT_ONE;
                        high_sat_next_s = 1'b0;
                        state_next_s    = HIGH;
                    end else if (!s_s) begin
                        if (low_cnt_r == CNT_MAX) begin
                            low_sat_next_s = 1'b1;
                        end else begin
                            low_cnt_next_s = low_cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_next_s = LOW;
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        frame_end_s     = 1'b1;
                        low_cnt_next_s  = CNT_ONE;
                        low_sat_next_s  = 1'b0;
                        high_sat_next_s = 1'b0;
                        state_next_s    = LOW;
                    end else if (s_s) begin
                        if (high_cnt_r == CNT_MAX) begin
                            high_sat_next_s = 1'b1;
                        end else begin
                            high_cnt_next_s = high_cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_next_s = HIGH;
                    end
                end
                default: begin
                    state_next_s    = IDLE;
                    low_cnt_next_s  = CNT_ZERO;
                    high_cnt_next_s = CNT_ZERO;
                    low_sat_next_s  = 1'b0;
                    high_sat_next_s = 1'b0;
                end
            endcase
        end
    end

    // Result registers and handshake: a completed frame loads when the slot
    // is free or is being accepted this cycle; otherwise it is dropped and
    // overrun is flagged until the held result is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r       <= CNT_ZERO;
            w_r       <= CNT_ZERO;
            sat_r     <= 1'b0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (frame_end_s && (!valid_r || ready)) begin
            d_r     <= low_cnt_r;
            w_r     <= high_cnt_r;
            sat_r   <= low_sat_r | high_sat_r;
            valid_r <= 1'b1;
        end else if (frame_end_s) begin
            overrun_r <= 1'b1;
        end else if (valid_r && ready) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign d_out   = d_r;
    assign w_out   = w_r;
    assign sat_out = sat_r;
    assign valid   = valid_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a run-length model of the delayed input stream
// predicts every result and handshake output each cycle; directed segments
// add literal expectations for the documented scenarios, followed by a
// randomized soak.
module tb_pwm_capture;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MAXV        = 15;
    localparam int HD          = SYNC_STAGES + 1;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             pulse_in = 1'b0;
    logic             enable   = 1'b1;
    logic             ready    = 1'b1;
    logic [WIDTH-1:0] d_out;
    logic [WIDTH-1:0] w_out;
    logic             sat_out;
    logic             valid;
    logic             overrun;

    pwm_capture #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .enable   (enable),
        .d_out    (d_out),
        .w_out    (w_out),
        .sat_out  (sat_out),
        .valid    (valid),
        .ready    (ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: input history, run length of the current level, frame
    // alignment and the result slot.
    int hist [0:9];
    int run;
    int low_len;
    bit aligned;
    bit high_ph;
    int m_d, m_w, m_sat;
    bit m_valid, m_ovr;

    typedef struct {
        int d;
        int w;
        int s;
    } res_t;
    res_t exp_q[$];
    int   exp_mode = 0;
    int   fix_cnt  = 0;
    bit   ph;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 10; i++) hist[i] = 0;
        run = 0; low_len = 0; aligned = 0; high_ph = 0;
        m_d = 0; m_w = 0; m_sat = 0; m_valid = 0; m_ovr = 0;
    endtask

    // The capture logic sees the input HD edges late; a frame is the low run
    // following an aligning fall plus the high run that follows it.
    task automatic model_step();
        int q, qp, prev_run, fd, fw, fs;
        bit fe;
        if (reset) begin
            model_clear();
            return;
        end
        for (int i = 9; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(pulse_in);
        q  = hist[HD];
        qp = hist[HD+1];
        fe = 0; fd = 0; fw = 0; fs = 0;
        prev_run = run;
        if (q != qp) run = 1;
        else if (run < 100000) run = run + 1;
        if (!enable) begin
            aligned = 0;
            high_ph = 0;
        end else if (q != qp) begin
            if (q == 0) begin
                if (aligned && high_ph) begin
                    fe = 1;
                    fd = (low_len > MAXV) ? MAXV : low_len;
                    fw = (prev_run > MAXV) ? MAXV : prev_run;
                    fs = ((low_len > MAXV) || (prev_run > MAXV)) ? 1 : 0;
                end
                aligned = 1;
                high_ph = 0;
            end else if (aligned) begin
                low_len = prev_run;
                high_ph = 1;
            end
        end
        if (fe) begin
            if (!m_valid || ready) begin
                m_d = fd; m_w = fw; m_sat = fs; m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && ready) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endtask

    // One clock: note what was offered before the edge, advance the model,
    // then compare every output away from the edge.
    task automatic cycle();
        bit   pv, pr;
        int   pd, pw, ps;
        res_t e;
        pv = (valid === 1'b1);
        pr = (ready === 1'b1);
        pd = int'(d_out); pw = int'(w_out); ps = int'(sat_out);
        @(posedge clk);
        model_step();
        #2;
        chk("valid",   int'(valid),   int'(m_valid));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("d_out",   int'(d_out),   m_d);
        chk("w_out",   int'(w_out),   m_w);
        chk("sat_out", int'(sat_out), m_sat);
        if (pv && pr) begin
            if (exp_mode == 1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lit_d",   pd, e.d);
                    chk("lit_w",   pw, e.w);
                    chk("lit_sat", ps, e.s);
                end
            end else if (exp_mode == 2) begin
                chk("min_d",   pd, 1);
                chk("min_w",   pw, 1);
                chk("min_sat", ps, 0);
                fix_cnt++;
            end
        end
    endtask

    task automatic drive(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in = lvl;
            cycle();
        end
    endtask

    task automatic do_reset();
        exp_q.delete();
        reset = 1'b1;
        pulse_in = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic push(input int d, input int w, input int s);
        res_t e;
        e.d = d; e.w = w; e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic alt_step();
        pulse_in = ph;
        ph = ~ph;
        cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   int'(valid),   0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_d"},       int'(d_out),   0);
        chk({tag, "_w"},       int'(w_out),   0);
        chk({tag, "_sat"},     int'(sat_out), 0);
    endtask

    initial begin
        bit lvl;
        bit found;
        int len;

        model_clear();
        do_reset();
        chk_all_zero("reset");

        // 3 low / 5 high, ready high: six frames, all (3,5,0).
        exp_mode = 1;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) push(3, 5, 0);
        drive(1'b1, 5);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3);
            drive(1'b1, 5);
        end
        drive(1'b0, 8);
        chk("t1_left", exp_q.size(), 0);

        // Generator-style 2 low / 3 high.
        do_reset();
        for (int i = 0; i < 5; i++) push(2, 3, 0);
        drive(1'b1, 3);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2);
            drive(1'b1, 3);
        end
        drive(1'b0, 8);
        chk("t2_left", exp_q.size(), 0);

        // Consumer stalled over two 4/2 frames: first held, second dropped.
        do_reset();
        ready = 1'b0;
        push(4, 2, 0);
        drive(1'b1, 2);
        drive(1'b0, 4);
        drive(1'b1, 2);
        drive(1'b0, 4);
        drive(1'b1, 2);
        drive(1'b0, 8);
        chk("t3_valid_held", int'(valid), 1);
        chk("t3_d_held",     int'(d_out), 4);
        chk("t3_w_held",     int'(w_out), 2);
        chk("t3_overrun",    int'(overrun), 1);
        ready = 1'b1;
        cycle();
        chk("t3_valid_clr",   int'(valid), 0);
        chk("t3_overrun_clr", int'(overrun), 0);
        cycle();
        chk("t3_left", exp_q.size(), 0);

        // Saturating low phase, then a normal frame clears sat.
        do_reset();
        ready = 1'b1;
        push(15, 2, 1);
        push(3, 3, 0);
        drive(1'b1, 2);
        drive(1'b0, 20);
        drive(1'b1, 2);
        drive(1'b0, 3);
        drive(1'b1, 3);
        drive(1'b0, 8);
        chk("t4_left", exp_q.size(), 0);

        // Minimum 1/1 frames: 20 falls, the first only aligns.
        do_reset();
        exp_mode = 2;
        fix_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            pulse_in = (i % 2 == 0);
            cycle();
        end
        drive(1'b0, 6);
        chk("t5_count", fix_cnt, 19);

        // Accept and frame end in the same cycle.
        do_reset();
        ph = 1'b1;
        for (int i = 0; i < 10; i++) alt_step();
        found = 0;
        for (int j = 0; j < 4 && !found; j++) begin
            alt_step();
            if (valid === 1'b1) found = 1;
        end
        chk("t5_valid_seen", int'(found), 1);
        ready = 1'b0;
        alt_step();
        chk("t5_valid_stall", int'(valid), 1);
        ready = 1'b1;
        alt_step();
        chk("t5_coinc_valid",   int'(valid), 1);
        chk("t5_coinc_overrun", int'(overrun), 0);
        chk("t5_coinc_d",       int'(d_out), 1);
        chk("t5_coinc_w",       int'(w_out), 1);
        alt_step();
        chk("t5_after_valid", int'(valid), 0);

        // Enable dropped mid-HIGH aborts the frame; next frame realigns.
        do_reset();
        exp_mode = 1;
        ready = 1'b1;
        push(3, 3, 0);
        drive(1'b1, 2);
        drive(1'b0, 3);
        drive(1'b1, 5);
        enable = 1'b0;
        drive(1'b1, 3);
        enable = 1'b1;
        drive(1'b1, 2);
        drive(1'b0, 3);
        drive(1'b1, 3);
        drive(1'b0, 8);
        chk("t6_left", exp_q.size(), 0);

        // Reset mid-LOW with a pending result.
        exp_mode = 0;
        do_reset();
        ready = 1'b0;
        drive(1'b1, 2);
        drive(1'b0, 3);
        drive(1'b1, 2);
        drive(1'b0, 6);
        chk("t6_pending", int'(valid), 1);
        reset = 1'b1;
        cycle();
        chk_all_zero("t6_reset");
        reset = 1'b0;

        // Randomized soak against the model.
        lvl = 1'b0;
        for (int r = 0; r < 250; r++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 18);
            for (int c = 0; c < len; c++) begin
                ready    = ($urandom_range(0, 9) < 7);
                enable   = ($urandom_range(0, 59) != 0);
                reset    = ($urandom_range(0, 799) == 0);
                pulse_in = lvl;
                cycle();
            end
        end
        reset  = 1'b0;
        enable = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
